// File: rtl/store_check_pkg.sv
// Shared types and helpers for the data-memory store-check monitor.
package store_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fail_code_t;

  // True when base <= addr < base + size; a zero size never matches.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr >= base) && (addr < (base + size));
  endfunction

endpackage

// File: rtl/store_check_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module store_check_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/store_check_monitor.sv
// Self-check monitor on the data-memory write port: matches an ordered list
// of expected stores, tolerates a scratch window, flags pass/mismatch/timeout.
// Optional build macro: STORE_CHECK_REARM_EN (start in PASS/FAIL re-arms).
module store_check_monitor
  import store_check_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_EXP    = 1,
  parameter int unsigned IGN_BASE = 96,
  parameter int unsigned IGN_SIZE = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned MI_W    = $clog2(N_EXP + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mem_write,
  input  logic [ADDR_W-1:0]       data_adr,
  input  logic [DATA_W-1:0]       write_data,
  input  logic [N_EXP*ADDR_W-1:0] exp_addr,
  input  logic [N_EXP*DATA_W-1:0] exp_data,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [1:0]              fail_code,
  output logic [ADDR_W-1:0]       fail_addr,
  output logic [DATA_W-1:0]       fail_data,
  output logic [MI_W-1:0]         match_idx,
  output logic [CNT_W-1:0]        store_cnt,
  output logic [CNT_W-1:0]        cycle_cnt
);

  state_t            state_q, state_d;
  logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [MI_W-1:0]   match_idx_q, match_idx_d;

  logic              cnt_clr, cyc_en, st_en;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              hit, in_win, timeout_hit;

  // Select the expected entry currently awaited.
  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int unsigned i = 0; i < N_EXP; i++) begin
      if (match_idx_q == MI_W'(i)) begin
        cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
        cur_data = exp_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign hit         = (data_adr == cur_addr) && (write_data == cur_data);
  assign in_win      = in_window(64'(data_adr), 64'(IGN_BASE), 64'(IGN_SIZE));
  assign timeout_hit = (64'(cycle_cnt) + 64'd1) >= 64'(TIMEOUT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_code_d = fail_code_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    match_idx_d = match_idx_q;
    cnt_clr     = 1'b0;
    cyc_en      = 1'b0;
    st_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          match_idx_d = '0;
          cnt_clr     = 1'b1;
        end
      end
      RUN: begin
        cyc_en = 1'b1;
        if (mem_write) begin
          st_en = 1'b1;
          if (hit) begin
            match_idx_d = match_idx_q + MI_W'(1);
            if (match_idx_q == MI_W'(N_EXP - 1)) begin
              state_d = PASS;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end
          end else if (!in_win) begin
            state_d     = FAIL;
            done_d      = 1'b1;
            fail_d      = 1'b1;
            fail_code_d = FC_MISMATCH;
            fail_addr_d = data_adr;
            fail_data_d = write_data;
          end
        end
        // Timeout only applies if this cycle's write did not already decide.
        if (timeout_hit && (state_d == RUN)) begin
          state_d     = FAIL;
          done_d      = 1'b1;
          fail_d      = 1'b1;
          fail_code_d = FC_TIMEOUT;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      default: begin
`ifdef STORE_CHECK_REARM_EN
        if (start) begin
          state_d     = RUN;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_code_d = FC_NONE;
          fail_addr_d = '0;
          fail_data_d = '0;
          match_idx_d = '0;
          cnt_clr     = 1'b1;
        end
`endif
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      match_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      match_idx_q <= match_idx_d;
    end
  end

  store_check_sat_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(cyc_en), .cnt(cycle_cnt)
  );

  store_check_sat_cnt #(.CNT_W(CNT_W)) u_store_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(st_en), .cnt(store_cnt)
  );

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign match_idx = match_idx_q;

endmodule
